// File: rtl/bus_sram_responder_pkg.sv
// Shared types and constants for the core-bus SRAM responder.
// word_t/ptr_t follow the core's bus word and word-pointer widths.
package bus_sram_responder_pkg;

    typedef logic [31:0] word_t;
    typedef logic [29:0] ptr_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } bus_state_t;

    localparam word_t BUS_UNMAPPED_DATA = 32'h0;
    localparam int    BUS_LAT_BITS      = 4;

    typedef logic [BUS_LAT_BITS-1:0] lat_cnt_t;

endpackage

// File: rtl/bus_sram_responder_array.sv
// Single-port synchronous SRAM: registered read, read-before-write on
// the same edge. Contents are never reset.
module bus_sram_array
    import bus_sram_responder_pkg::*;
#(
    parameter int ADDR_BITS = 12
) (
    input  logic                 clk,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic                 we,
    input  word_t                wdata,
    input  logic                 re,
    output word_t                rdata
);

    word_t mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[addr];
        end
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/bus_sram_responder.sv
// Target end of the core bus: one outstanding access, programmable wait
// states, SRAM backing store, sticky fault on unmapped/overlapping starts.
module bus_sram_responder
    import bus_sram_responder_pkg::*;
#(
    parameter int ADDR_BITS     = 12,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 1
) (
    input  logic  clk,
    input  logic  rst_n,
    input  ptr_t  bus_addr,
    input  logic  bus_start,
    input  logic  bus_write,
    input  word_t bus_data_wr,
    output logic  bus_ready,
    output word_t bus_data_rd,
    output logic  busy,
    output logic  fault
);

    if (READ_LATENCY < 1 || READ_LATENCY > 15) begin : g_bad_read_latency
        $fatal(1, "READ_LATENCY must be in 1..15");
    end
    if (WRITE_LATENCY < 1 || WRITE_LATENCY > 15) begin : g_bad_write_latency
        $fatal(1, "WRITE_LATENCY must be in 1..15");
    end
    if (ADDR_BITS < 1 || ADDR_BITS > 29) begin : g_bad_addr_bits
        $fatal(1, "ADDR_BITS must be in 1..29");
    end

    localparam lat_cnt_t RD_LOAD = lat_cnt_t'(READ_LATENCY - 1);
    localparam lat_cnt_t WR_LOAD = lat_cnt_t'(WRITE_LATENCY - 1);

    bus_state_t           state;
    lat_cnt_t             cnt;
    logic [ADDR_BITS-1:0] addr_q;
    logic                 write_q;
    word_t                wdata_q;
    logic                 mapped_q;

    logic                 start_mapped;
    lat_cnt_t             start_load;
    logic [ADDR_BITS-1:0] ram_addr;
    logic                 ram_we;
    logic                 ram_re;
    word_t                ram_rdata;

    // The read is launched one cycle ahead of RESP so the registered
    // array output lines up with bus_ready.
    always_comb begin
        start_mapped = (bus_addr[29:ADDR_BITS] == '0);
        start_load   = bus_write ? WR_LOAD : RD_LOAD;
        ram_we       = (state == RESP) && write_q && mapped_q;
        ram_re       = 1'b0;
        ram_addr     = addr_q;
        if (state == IDLE) begin
            ram_addr = bus_addr[ADDR_BITS-1:0];
            ram_re   = bus_start && !bus_write && start_mapped && (start_load == '0);
        end else if (state == WAIT) begin
            ram_re = !write_q && mapped_q && (cnt == lat_cnt_t'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            mapped_q  <= 1'b0;
            busy      <= 1'b0;
            fault     <= 1'b0;
            bus_ready <= 1'b0;
        end else begin
            bus_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus_start) begin
                        addr_q   <= bus_addr[ADDR_BITS-1:0];
                        write_q  <= bus_write;
                        wdata_q  <= bus_data_wr;
                        mapped_q <= start_mapped;
                        cnt      <= start_load;
                        busy     <= 1'b1;
                        if (start_load == '0) begin
                            state     <= RESP;
                            bus_ready <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (bus_start) begin
                        fault <= 1'b1;
                    end
                    cnt <= cnt - lat_cnt_t'(1);
                    if (cnt == lat_cnt_t'(1)) begin
                        state     <= RESP;
                        bus_ready <= 1'b1;
                    end
                end
                RESP: begin
                    if (bus_start || !mapped_q) begin
                        fault <= 1'b1;
                    end
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus_data_rd = (bus_ready && !write_q)
                         ? (mapped_q ? ram_rdata : BUS_UNMAPPED_DATA)
                         : '0;

    bus_sram_array #(
        .ADDR_BITS(ADDR_BITS)
    ) u_array (
        .clk  (clk),
        .addr (ram_addr),
        .we   (ram_we),
        .wdata(wdata_q),
        .re   (ram_re),
        .rdata(ram_rdata)
    );

endmodule

// File: doc/bus_sram_responder.md
Name: bus_sram_responder

Overview:
- Word-addressed bus responder: the target end of the core bus driven by the CPU core's bus_start/bus_ready handshake.
- Backs the bus with an on-chip single-port SRAM and a programmable wait-state counter.
- Flags unmapped accesses and protocol violations with sticky outputs.
- Sits between the core's bus port and the system memory map; one outstanding transaction at a time.

Parameters:
- ADDR_BITS, 12, number of implemented word-address bits; mapped range is words 0 .. 2**ADDR_BITS-1.
- READ_LATENCY, 2, cycles from start to ready for reads; legal range 1..15.
- WRITE_LATENCY, 1, cycles from start to ready for writes; legal range 1..15.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- bus_addr  in  30  word address (ptr); sampled only in the start cycle.
- bus_start  in  1  one-cycle request strobe.
- bus_write  in  1  1 = write, 0 = read; sampled with bus_start.
- bus_data_wr  in  32  write data (word); sampled with bus_start.
- bus_ready  out  1  one-cycle completion strobe.
- bus_data_rd  out  32  read data (word); valid only while bus_ready=1 on a read, else 0.
- busy  out  1  transaction outstanding (start accepted, ready not yet given).
- fault  out  1  sticky: unmapped access or start while busy seen since reset.

Behaviour:
- Reset values: bus_ready=0, bus_data_rd=0, busy=0, fault=0, FSM=IDLE, counter=0. SRAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE with bus_start=1:
  - capture addr, write, data, and mapped = (bus_addr[29:ADDR_BITS]==0);
  - load counter with latency-1 for the access kind;
  - go to RESP if that value is 0, else WAIT; busy=1 from the next cycle.
- WAIT: decrement counter; on reaching 0 go to RESP.
- RESP: bus_ready=1 for exactly this cycle.
  - Mapped write: SRAM updated at the end of this cycle.
  - Mapped read: bus_data_rd = SRAM[addr].
  - Unmapped read: bus_data_rd=0; unmapped write: dropped. In both cases fault is set at the end of this cycle.
  - Next state IDLE; busy=0 next cycle.
- Latency: start at cycle t gives bus_ready at cycle t+LATENCY exactly (LATENCY=1 means ready the cycle after start).
- Back-to-back: bus_start may assert in the cycle after RESP. That access observes any write committed in RESP.
- Start in the RESP cycle or in WAIT: ignored, fault set, the in-flight transaction is unaffected.
- The SRAM read is issued one cycle before RESP, registered, and emitted in RESP. The array is synchronous with one-cycle read.
- bus_data_wr and bus_addr are don't-care outside the start cycle.
- Reset mid-transaction: the transaction is abandoned, no bus_ready, and a pending write is not committed. fault is cleared.
- Counter is 4 bits wide. Parameter values outside 1..15 are an elaboration error (assertion).

Decomposition:
- Reuse the existing word and ptr typedefs from the core uarch include.
- New shared bus package holds:
  - bus_state enum (IDLE/WAIT/RESP);
  - BUS_UNMAPPED_DATA constant (32'h0);
  - the latency-counter width.
- One sub-module, bus_sram_array:
  - ports: clk, addr[ADDR_BITS], we, wdata[32], re, rdata[32];
  - synchronous single-port, read-before-write, registered read.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with bus_start toggling -> bus_ready=0, busy=0, fault=0, bus_data_rd=0 throughout.
- Write then read, defaults: write 32'hCAFE_F00D to 30'h10 at cycle t -> ready at t+1. Read 30'h10 at t+2 -> ready at t+4 with bus_data_rd=32'hCAFE_F00D. fault stays 0.
- Back-to-back: write 30'h0=32'h1 in RESP-adjacent cycles, then immediately read 30'h0 -> 32'h1 returned. No idle cycle required between transactions.
- Unmapped: read 30'h1000 (ADDR_BITS=12) -> ready at t+2 with data 0, fault=1 from t+3. A write to 30'h2000 leaves all mapped words unchanged.
- Protocol violation: assert bus_start during WAIT of a read to 30'h5 -> fault=1, exactly one bus_ready, and the data of 30'h5 returned.
- Reset mid-write: start write 32'hFFFF_FFFF to 30'h7 with WRITE_LATENCY=4, drop rst_n at t+2 -> no ready. A later read of 30'h7 returns its prior value.
